// File: rtl/pipelined_adder.sv
// WIDTH-bit add/sub, carry chain cut into CHUNK-bit slices, one register per slice, plus output register.
// Latency STAGES+... : result visible STAGES cycles after acceptance; whole pipe stalls when out_valid && !out_ready.
// Optional PADDER_OVF_EN adds the registered signed-overflow output ovf.
module pipelined_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef PADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int STAGES = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int LAST   = STAGES - 1;

    logic [STAGES-1:0] st_vld;
    logic [WIDTH-1:0]  st_a [STAGES];
    logic [WIDTH-1:0]  st_b [STAGES];
    logic [WIDTH-1:0]  st_s [STAGES];
    logic              st_c [STAGES];

    logic [WIDTH-1:0]  nx_a [STAGES];
    logic [WIDTH-1:0]  nx_b [STAGES];
    logic [WIDTH-1:0]  nx_s [STAGES];
    logic              nx_c [STAGES];

    logic advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        localparam int LO = k * CHUNK;
        localparam int SW = (WIDTH - LO < CHUNK) ? (WIDTH - LO) : CHUNK;

        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_b;
        logic [WIDTH-1:0] src_s;
        logic             src_c;
        logic [SW:0]      tot;

        if (k == 0) begin : g_first
            // Subtraction is A + ~B + ~borrow_in.
            assign src_a = a;
            assign src_b = sub ? ~b : b;
            assign src_s = '0;
            assign src_c = sub ^ carry_in;
        end else begin : g_next
            assign src_a = st_a[k-1];
            assign src_b = st_b[k-1];
            assign src_s = st_s[k-1];
            assign src_c = st_c[k-1];
        end

        assign tot     = {1'b0, src_a[LO +: SW]} + {1'b0, src_b[LO +: SW]} + {{SW{1'b0}}, src_c};
        assign nx_a[k] = src_a;
        assign nx_b[k] = src_b;
        assign nx_c[k] = tot[SW];
        // Bits at and above LO are still zero here, so OR-ing the slice in is enough.
        assign nx_s[k] = src_s | (WIDTH'(tot[SW-1:0]) << LO);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_vld    <= '0;
            out_valid <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                st_a[k] <= '0;
                st_b[k] <= '0;
                st_s[k] <= '0;
                st_c[k] <= 1'b0;
            end
        end else if (advance) begin
            st_vld[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                st_vld[k] <= st_vld[k-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                st_a[k] <= nx_a[k];
                st_b[k] <= nx_b[k];
                st_s[k] <= nx_s[k];
                st_c[k] <= nx_c[k];
            end
            out_valid <= st_vld[LAST];
            // Result registers only load real beats so they hold across bubbles.
            if (st_vld[LAST]) begin
                sum       <= st_s[LAST];
                carry_out <= st_c[LAST];
            end
        end
    end

`ifdef PADDER_OVF_EN
    logic msb_cin;

    assign msb_cin = st_a[LAST][WIDTH-1] ^ st_b[LAST][WIDTH-1] ^ st_s[LAST][WIDTH-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf <= 1'b0;
        end else if (advance && st_vld[LAST]) begin
            ovf <= msb_cin ^ st_c[LAST];
        end
    end
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and randomised checks of pipelined_adder (8/2 and 7/3 configurations) against hand values and a reference model.
module tb_pipelined_adder;

    logic       clk = 1'b0;
    logic       rstn;

    logic       in_valid, in_ready, carry_in, sub, out_valid, out_ready, carry_out;
    logic [7:0] a, b, sum;

    logic       in_valid_7, in_ready_7, carry_in_7, sub_7, out_valid_7, out_ready_7, carry_out_7;
    logic [6:0] a_7, b_7, sum_7;

`ifdef PADDER_OVF_EN
    logic       ovf, ovf_7;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] q8[$];
    logic [31:0] q7[$];
    logic [31:0] e8, e7;
    int acc8 = 0, out8 = 0, acc7 = 0, out7 = 0;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(8), .CHUNK(2)) u_dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .carry_in(carry_in), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry_out(carry_out)
`ifdef PADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    pipelined_adder #(.WIDTH(7), .CHUNK(3)) u_dut7 (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid_7), .in_ready(in_ready_7),
        .a(a_7), .b(b_7), .carry_in(carry_in_7), .sub(sub_7),
        .out_valid(out_valid_7), .out_ready(out_ready_7),
        .sum(sum_7), .carry_out(carry_out_7)
`ifdef PADDER_OVF_EN
        , .ovf(ovf_7)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Returns {ovf, carry_out, sum} for a w-bit operation.
    function automatic logic [31:0] ref_res(input int w, input int av, input int bv, input int ci, input int sb);
        int full, sa, sbv, r, lim;
        logic co, ov;
        lim = 1 << (w - 1);
        if (sb == 0) begin
            full = av + bv + ci;
            co   = (full >= (1 << w));
        end else begin
            full = av - bv - ci;
            co   = (full >= 0);
        end
        sa  = (av >= lim) ? av - 2 * lim : av;
        sbv = (bv >= lim) ? bv - 2 * lim : bv;
        r   = (sb != 0) ? sa - sbv - ci : sa + sbv + ci;
        ov  = (r >= lim) || (r < -lim);
        return (32'(ov) << (w + 1)) | (32'(co) << w) | (32'(full) & ((32'd1 << w) - 1));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (out_valid && out_ready) begin
                chk("q8_head", 32'(q8.size() != 0), 32'd1);
                if (q8.size() != 0) begin
                    e8 = q8.pop_front();
                    chk("sum8", 32'(sum), 32'(e8[7:0]));
                    chk("cout8", 32'(carry_out), 32'(e8[8]));
`ifdef PADDER_OVF_EN
                    chk("ovf8", 32'(ovf), 32'(e8[9]));
`endif
                    out8++;
                end
            end
            if (in_valid && in_ready) begin
                q8.push_back(ref_res(8, int'(a), int'(b), int'(carry_in), int'(sub)));
                acc8++;
            end
            if (out_valid_7 && out_ready_7) begin
                chk("q7_head", 32'(q7.size() != 0), 32'd1);
                if (q7.size() != 0) begin
                    e7 = q7.pop_front();
                    chk("sum7", 32'(sum_7), 32'(e7[6:0]));
                    chk("cout7", 32'(carry_out_7), 32'(e7[7]));
`ifdef PADDER_OVF_EN
                    chk("ovf7", 32'(ovf_7), 32'(e7[8]));
`endif
                    out7++;
                end
            end
            if (in_valid_7 && in_ready_7) begin
                q7.push_back(ref_res(7, int'(a_7), int'(b_7), int'(carry_in_7), int'(sub_7)));
                acc7++;
            end
        end
    end

    // One beat into the 8-bit pipe; result must appear exactly 4 cycles after acceptance, for one cycle.
    task automatic send_one(input logic [7:0] av, input logic [7:0] bv, input logic ci, input logic sb,
                            input logic [7:0] es, input logic ec, input logic eo, input string tag);
        in_valid  = 1'b1;
        a         = av;
        b         = bv;
        carry_in  = ci;
        sub       = sb;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk({tag, "_vld"}, 32'(out_valid), 32'(k == 4));
            if (k == 4) begin
                chk({tag, "_sum"}, 32'(sum), 32'(es));
                chk({tag, "_cout"}, 32'(carry_out), 32'(ec));
`ifdef PADDER_OVF_EN
                chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
                if (eo) begin end
`endif
            end
        end
    endtask

    initial begin
        int base_acc, base_out, guard;

        rstn = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
        in_valid_7 = 1'b0; a_7 = '0; b_7 = '0; carry_in_7 = 1'b0; sub_7 = 1'b0; out_ready_7 = 1'b1;

        #12;
        chk("rst_vld", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(carry_out), 32'd0);
        chk("rst_vld7", 32'(out_valid_7), 32'd0);
`ifdef PADDER_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        #10 rstn = 1'b1;
        tick();
        chk("rst_inrdy", 32'(in_ready), 32'd1);

        send_one(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "t1");
        send_one(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, "t2");
        send_one(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, "t2ovf");
        send_one(8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, "t2add");

        // Streaming: 10 beats, results 2i+1 on consecutive cycles.
        out_ready = 1'b1;
        for (int t = 0; t < 16; t++) begin
            if (t < 10) begin
                in_valid = 1'b1; a = 8'(t); b = 8'(t); carry_in = 1'b1; sub = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (t + 1 >= 5 && t + 1 <= 14) begin
                chk("t3_vld", 32'(out_valid), 32'd1);
                chk("t3_sum", 32'(sum), 32'(2 * (t + 1 - 5) + 1));
            end else if (t + 1 > 14) begin
                chk("t3_idle", 32'(out_valid), 32'd0);
            end
        end

        // Back-pressure: sink stalls for 6 cycles while the source keeps offering.
        base_acc = acc8;
        base_out = out8;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; a = 8'h10 + 8'(i); b = 8'h20; carry_in = 1'b0; sub = 1'b0;
            tick();
            if (out_valid) begin
                chk("t4_inrdy", 32'(in_ready), 32'd0);
                if (q8.size() != 0) chk("t4_hold", 32'(sum), 32'(q8[0][7:0]));
            end
        end
        chk("t4_full", 32'(out_valid), 32'd1);
        chk("t4_acc", 32'(acc8 - base_acc), 32'd5);
        in_valid = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (q8.size() != 0 && guard < 30) begin
            tick();
            guard++;
        end
        chk("t4_drain", 32'(q8.size()), 32'd0);
        chk("t4_out", 32'(out8 - base_out), 32'd5);

        // Reset with beats in flight.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a = 8'h30 + 8'(i); b = 8'h11; carry_in = 1'b0; sub = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        chk("t5_pre_vld", 32'(out_valid), 32'd1);
        chk("t5_pre_sum", 32'(sum), 32'h41);
        #2 rstn = 1'b0;
        #1;
        chk("t5_vld", 32'(out_valid), 32'd0);
        chk("t5_sum", 32'(sum), 32'd0);
        chk("t5_cout", 32'(carry_out), 32'd0);
        q8.delete();
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        chk("t5_inrdy", 32'(in_ready), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t5_stale", 32'(out_valid), 32'd0);
        end

        // 7-bit / 3-bit slices: latency 3, then random traffic with random back-pressure.
        in_valid_7 = 1'b1; a_7 = 7'h7F; b_7 = 7'h01; carry_in_7 = 1'b0; sub_7 = 1'b0; out_ready_7 = 1'b1;
        tick();
        in_valid_7 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("t6_vld", 32'(out_valid_7), 32'(k == 3));
            if (k == 3) begin
                chk("t6_sum", 32'(sum_7), 32'd0);
                chk("t6_cout", 32'(carry_out_7), 32'd1);
            end
        end
        for (int i = 0; i < 400; i++) begin
            in_valid_7  = ($urandom_range(0, 3) != 0);
            a_7         = 7'($urandom_range(0, 127));
            b_7         = 7'($urandom_range(0, 127));
            carry_in_7  = 1'($urandom_range(0, 1));
            sub_7       = 1'($urandom_range(0, 1));
            out_ready_7 = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid_7 = 1'b0;
        out_ready_7 = 1'b1;
        guard = 0;
        while (q7.size() != 0 && guard < 30) begin
            tick();
            guard++;
        end
        chk("t6_drain", 32'(q7.size()), 32'd0);
        chk("t6_count", 32'(out7), 32'(acc7));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
